// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and data bundle for alu_pipe.
//   master : issue-stage / testbench side (drives operands, opcode, out_ready)
//   slave  : alu_pipe side (drives in_ready, result, flags, busy)
// Signals:
//   in_valid/in_ready    operand handshake
//   a, b, sel            operands and 4-bit opcode
//   out_valid/out_ready  result handshake
//   result, Carry_out    registered result and carry/borrow/overflow
//   zero, busy           result==0 flag, multiplier iterating
interface alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             Carry_out;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, Carry_out, zero, busy
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, Carry_out, zero, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides, a stored carry
// flag for add-with-carry chains, and a WIDTH-step shift-add multiplier.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_pipe_if slave modport (operand/result handshakes and flags)
//
// state | meaning
// IDLE  | accepting operands; single-cycle ops complete here
// MUL   | shift-add iterating, one partial product per cycle
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  alu_pipe_if.slave  bus
);
  localparam int LOG = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q, zero_q, out_valid_q, cflag_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [LOG-1:0]     cnt_q;

  logic               in_ready, accept, mul_done, is_mul, updates_cflag;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic [WIDTH:0]     wide;
  logic [LOG-1:0]     amt;

  assign in_ready      = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign is_mul        = (bus.sel == OP_MUL);
  assign updates_cflag = (bus.sel == OP_ADD) || (bus.sel == OP_SUB) || (bus.sel == OP_ADC);
  assign amt           = bus.b[LOG-1:0];
  assign acc_step      = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath. Shifts run one bit wider so the last bit shifted
  // out lands in the extra position; a zero shift leaves it 0.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    wide  = '0;
    case (bus.sel)
      OP_ADD: {alu_c, alu_r} = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB: begin
        alu_r = bus.a - bus.b;
        alu_c = (bus.a < bus.b);
      end
      OP_ADC: {alu_c, alu_r} = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cflag_q};
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_NOT: alu_r = ~bus.a;
      OP_SHL: begin
        wide  = {1'b0, bus.a} << amt;
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      OP_SHR: begin
        wide  = {bus.a, 1'b0} >> amt;
        alu_r = wide[WIDTH:1];
        alu_c = wide[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL: begin
        if (cnt_q == LOG'(WIDTH - 1)) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cflag_q     <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      // Drain first; a result loading on the same edge overrides this.
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (is_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            result_q    <= alu_r;
            carry_q     <= alu_c;
            zero_q      <= (alu_r == '0);
            out_valid_q <= 1'b1;
            if (updates_cflag) cflag_q <= alu_c;
          end
        end
      end else begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + LOG'(1);
        if (mul_done) begin
          result_q    <= acc_step[WIDTH-1:0];
          carry_q     <= |acc_step[2*WIDTH-1:WIDTH];
          zero_q      <= (acc_step[WIDTH-1:0] == '0);
          out_valid_q <= 1'b1;
          cflag_q     <= |acc_step[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.Carry_out = carry_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q == MUL);
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe at WIDTH=16
// against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mcflag    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] r, input logic c, input logic z);
    chk({tag, "_res"},   32'(bus.result),    32'(r));
    chk({tag, "_carry"}, 32'(bus.Carry_out), 32'(c));
    chk({tag, "_zero"},  32'(bus.zero),      32'(z));
  endtask

  // Reference: {carry, result} from plain integer arithmetic.
  function automatic logic [16:0] ref_alu(input logic [3:0] s, input logic [15:0] x,
                                          input logic [15:0] y, input bit cf);
    longint unsigned ax, by, p, r;
    int amt;
    bit c;
    ax  = 64'(x);
    by  = 64'(y);
    amt = int'(y % 16);
    r   = 0;
    c   = 1'b0;
    case (s)
      4'd0: begin p = ax + by; r = p % 65536; c = (p >= 65536); end
      4'd1: begin r = (ax + 65536 - by) % 65536; c = (ax < by); end
      4'd2: begin p = ax * by; r = p % 65536; c = (p >= 65536); end
      4'd3: begin p = ax + by + 64'(cf); r = p % 65536; c = (p >= 65536); end
      4'd4: r = ax & by;
      4'd5: r = ax | by;
      4'd6: r = ax ^ by;
      4'd7: r = 65535 - ax;
      4'd8: begin
        r = (ax << amt) % 65536;
        c = (amt == 0) ? 1'b0 : (((ax >> (16 - amt)) & 1) == 1);
      end
      4'd9: begin
        r = ax >> amt;
        c = (amt == 0) ? 1'b0 : (((ax >> (amt - 1)) & 1) == 1);
      end
      default: ;
    endcase
    return {c, r[15:0]};
  endfunction

  // Issue one op with out_ready as currently driven; returns at the negedge
  // where the result is first visible.
  task automatic op(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y,
                    input string tag);
    logic [16:0] e;
    int w, k, busyc, rdyc;
    e = ref_alu(s, x, y, mcflag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel = s;
    bus.a = x;
    bus.b = y;
    w = 0;
    while (!bus.in_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_accept_timeout"}, 32'(w < 64), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.sel = 4'($urandom);
    k = 0;
    busyc = 0;
    rdyc = 0;
    while (!bus.out_valid && k < 64) begin
      if (bus.busy) busyc++;
      if (bus.in_ready) rdyc++;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), (s == 4'd2) ? 32'd16 : 32'd0);
    if (s == 4'd2) begin
      chk({tag, "_busy_cycles"}, 32'(busyc), 32'd16);
      chk({tag, "_ready_while_busy"}, 32'(rdyc), 32'd0);
    end
    expect_out(tag, e[15:0], e[16], (e[15:0] == 16'd0));
    if (s <= 4'd3) mcflag = e[16];
  endtask

  initial begin : main
    int stale;
    logic [3:0] rs;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sel       = '0;
    bus.out_ready = 1'b1;

    // Reset values and no transfer while held in reset.
    #2;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flags", 32'({bus.Carry_out, bus.zero}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = 16'd1;
    bus.b = 16'd1;
    @(posedge clk);
    #1 chk("rst_no_accept", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", 32'(bus.out_valid), 32'd0);

    // Directed arithmetic and carry-flag chaining.
    op(4'd0, 16'd10, 16'd6, "add");
    expect_out("add_k", 16'd16, 1'b0, 1'b0);
    op(4'd1, 16'd10, 16'd6, "sub");
    expect_out("sub_k", 16'd4, 1'b0, 1'b0);
    op(4'd1, 16'd6, 16'd10, "sub_borrow");
    expect_out("sub_borrow_k", 16'hFFFC, 1'b1, 1'b0);
    op(4'd0, 16'hFFFF, 16'd1, "add_ovf");
    expect_out("add_ovf_k", 16'h0000, 1'b1, 1'b1);
    op(4'd3, 16'd0, 16'd0, "adc1");
    expect_out("adc1_k", 16'd1, 1'b0, 1'b0);
    op(4'd4, 16'hF0F0, 16'h0FF0, "and");
    expect_out("and_k", 16'h00F0, 1'b0, 1'b0);
    op(4'd3, 16'd0, 16'd0, "adc2");
    expect_out("adc2_k", 16'd0, 1'b0, 1'b1);
    op(4'd0, 16'hFFFF, 16'd1, "add_ovf2");
    op(4'd5, 16'h1234, 16'h0001, "or_hold");
    op(4'd3, 16'd0, 16'd0, "adc_held");
    expect_out("adc_held_k", 16'd1, 1'b0, 1'b0);

    // Multiplier.
    op(4'd2, 16'd200, 16'd100, "mul");
    expect_out("mul_k", 16'h4E20, 1'b0, 1'b0);
    op(4'd2, 16'hFFFF, 16'd2, "mul_ovf");
    expect_out("mul_ovf_k", 16'hFFFE, 1'b1, 1'b0);

    // Shifts and reserved opcode.
    op(4'd8, 16'h8001, 16'd1, "shl");
    expect_out("shl_k", 16'h0002, 1'b1, 1'b0);
    op(4'd9, 16'h0003, 16'h0011, "shr");
    expect_out("shr_k", 16'h0001, 1'b1, 1'b0);
    op(4'd8, 16'h1234, 16'd16, "shl_wrap");
    expect_out("shl_wrap_k", 16'h1234, 1'b0, 1'b0);
    op(4'hC, 16'h1234, 16'h5678, "rsvd");
    expect_out("rsvd_k", 16'h0000, 1'b0, 1'b1);

    // Back-to-back throughput.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel = 4'd0;
    bus.a = 16'd1;
    bus.b = 16'd1;
    @(negedge clk);
    chk("b2b_valid1", 32'(bus.out_valid), 32'd1);
    chk("b2b_res1", 32'(bus.result), 32'd2);
    bus.a = 16'd2;
    bus.b = 16'd2;
    @(negedge clk);
    chk("b2b_valid2", 32'(bus.out_valid), 32'd1);
    chk("b2b_res2", 32'(bus.result), 32'd4);
    bus.in_valid = 1'b0;
    mcflag = 1'b0;

    // Backpressure with a pending XOR.
    @(negedge clk);
    bus.out_ready = 1'b0;
    op(4'd0, 16'd1, 16'd2, "bp_add");
    bus.in_valid = 1'b1;
    bus.sel = 4'd6;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_res", 32'(bus.result), 32'd3);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_ready_on_drain", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_valid_kept", 32'(bus.out_valid), 32'd1);
    expect_out("bp_xor", 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      rs = (i % 4 == 3) ? 4'd3 : 4'($urandom_range(0, 15));
      op(rs, 16'($urandom), 16'($urandom), "rnd");
    end

    // Reset in the middle of a multiply.
    op(4'd0, 16'd5, 16'd6, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel = 4'd2;
    bus.a = 16'd200;
    bus.b = 16'd100;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_mul_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_flags", 32'({bus.Carry_out, bus.zero}), 32'd0);
    mcflag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    op(4'd0, 16'd5, 16'd5, "post_rst");
    expect_out("post_rst_k", 16'd10, 1'b0, 1'b0);
    op(4'd3, 16'd1, 16'd1, "post_rst_adc");
    expect_out("post_rst_adc_k", 16'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
